// File: rtl/eq_band_mixer_pkg.sv
// Shared types and width helpers for the EQ band mixer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, acc_w() accumulator width, unity() gain of 1.0.
package eq_mix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    VOL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Worst case sum of NB products of a W-bit sample and a (GW+1)-bit signed gain.
  function automatic int acc_w(input int w, input int gw, input int nb);
    return w + gw + 1 + $clog2(nb);
  endfunction

  // Gain/volume code for unity (1.0).
  function automatic int unity(input int gw);
    return 1 << (gw - 1);
  endfunction

endpackage

// File: rtl/eq_band_mixer_if.sv
// Band frame in / mixed frame out bus of the EQ band mixer.
// Latency: n/a (wires only).
// Backpressure: band_vld is honoured only while in_rdy=1; otherwise the frame is dropped and overrun flags it.
// master = band-filter side (drives frames, clr_ovr); slave = mixer (drives in_rdy, out_vld, out_data, overrun).
interface eq_band_mixer_if #(
  parameter int W  = 16,
  parameter int NB = 5,
  parameter int CH = 2,
  parameter int GW = 12
);
  logic                 band_vld;
  logic [CH*NB*W-1:0]   band_in;
  logic [NB*GW-1:0]     gain;
  logic [GW-1:0]        volume;
  logic                 in_rdy;
  logic                 out_vld;
  logic [CH*W-1:0]      out_data;
  logic                 overrun;
  logic                 clr_ovr;

  modport master (
    output band_vld, band_in, gain, volume, clr_ovr,
    input  in_rdy, out_vld, out_data, overrun
  );

  modport slave (
    input  band_vld, band_in, gain, volume, clr_ovr,
    output in_rdy, out_vld, out_data, overrun
  );
endinterface

// File: rtl/eq_band_mixer_sat.sv
// eq_sat: signed saturation of an IN_W-bit value to OUT_W bits.
// Latency: combinational.
// Backpressure: none.
// Ports: din (signed IN_W), dout (signed OUT_W, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]).
module eq_sat #(
  parameter int IN_W  = 45,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > MAX_V) begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (din < MIN_V) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end
endmodule

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: per-band gain, band sum, master volume and saturation for CH channels on one shared multiplier.
// Latency: accept at cycle T -> out_vld at T+CH*(NB+1)+1; one frame in flight, next accept CH*(NB+1)+2 cycles later.
// Backpressure: in_rdy high only in IDLE; band_vld while busy drops the frame and sets sticky overrun.
// Ports: clk, rst_n (async active-low), bus (eq_band_mixer_if.slave).
// Build option: define EQ_VOL_RAMP_EN to slew the applied volume by at most VOL_STEP per accepted frame.
module eq_band_mixer
  import eq_mix_pkg::*;
#(
  parameter int W        = 16,
  parameter int NB       = 5,
  parameter int CH       = 2,
  parameter int GW       = 12,
  parameter int VOL_STEP = 16
) (
  input logic            clk,
  input logic            rst_n,
  eq_band_mixer_if.slave bus
);
  localparam int ACC_W = acc_w(W, GW, NB);
  localparam int P_W   = ACC_W + GW + 1;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(NB - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CH - 1);

  state_t                    state;
  logic [CH*NB*W-1:0]        band_r;
  logic [NB*GW-1:0]          gain_r;
  logic [GW-1:0]             vol_r;
  logic signed [ACC_W-1:0]   acc;
  logic [BW-1:0]             b_idx;
  logic [CW-1:0]             c_idx;
  logic                      in_rdy_r;
  logic                      out_vld_r;
  logic [CH*W-1:0]           out_data_r;
  logic                      overrun_r;

  logic [GW-1:0]             vol_load;
  logic signed [W-1:0]       samp;
  logic [GW-1:0]             g_sel;
  logic signed [ACC_W-1:0]   t_val;
  logic signed [ACC_W-1:0]   op_a;
  logic signed [GW:0]        op_b;
  logic signed [P_W-1:0]     prod;
  logic signed [P_W-1:0]     v_val;
  logic signed [W-1:0]       sat_out;

`ifdef EQ_VOL_RAMP_EN
  localparam logic [GW-1:0] STEP = GW'(VOL_STEP);
  logic [GW-1:0] vol_eff;
  logic [GW-1:0] vol_next;

  // Move toward the requested volume by at most STEP; the new value applies to the frame being accepted.
  always_comb begin
    vol_next = vol_eff;
    if (bus.volume > vol_eff) begin
      vol_next = ((bus.volume - vol_eff) > STEP) ? (vol_eff + STEP) : bus.volume;
    end else begin
      vol_next = ((vol_eff - bus.volume) > STEP) ? (vol_eff - STEP) : bus.volume;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vol_eff <= '0;
    end else if (state == IDLE && bus.band_vld) begin
      vol_eff <= vol_next;
    end
  end

  assign vol_load = vol_next;
`else
  // The slew step has no effect without the ramp.
  localparam int unused_vol_step = VOL_STEP;
  assign vol_load = bus.volume;
`endif

  // Shared multiplier: sample x band gain in MAC, scaled sum x volume in VOL.
  assign samp  = band_r[(int'(c_idx)*NB + int'(b_idx))*W +: W];
  assign g_sel = gain_r[int'(b_idx)*GW +: GW];
  assign t_val = acc >>> (GW - 1);
  assign op_a  = (state == VOL) ? t_val : $signed({{(ACC_W-W){samp[W-1]}}, samp});
  assign op_b  = (state == VOL) ? $signed({1'b0, vol_r}) : $signed({1'b0, g_sel});
  assign prod  = P_W'(op_a) * P_W'(op_b);
  assign v_val = prod >>> (GW - 1);

  eq_sat #(.IN_W(P_W), .OUT_W(W)) u_sat (
    .din  (v_val),
    .dout (sat_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      band_r     <= '0;
      gain_r     <= '0;
      vol_r      <= '0;
      acc        <= '0;
      b_idx      <= '0;
      c_idx      <= '0;
      in_rdy_r   <= 1'b1;
      out_vld_r  <= 1'b0;
      out_data_r <= '0;
      overrun_r  <= 1'b0;
    end else begin
      out_vld_r <= 1'b0;
      // Clear has priority so software never loses a clear to a simultaneous overrun.
      if (bus.clr_ovr) begin
        overrun_r <= 1'b0;
      end else if (bus.band_vld && !in_rdy_r) begin
        overrun_r <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.band_vld) begin
            band_r   <= bus.band_in;
            gain_r   <= bus.gain;
            vol_r    <= vol_load;
            acc      <= '0;
            b_idx    <= '0;
            c_idx    <= '0;
            in_rdy_r <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc + $signed(prod[ACC_W-1:0]);
          if (b_idx == B_LAST) begin
            state <= VOL;
          end else begin
            b_idx <= b_idx + 1'b1;
          end
        end
        VOL: begin
          out_data_r[int'(c_idx)*W +: W] <= sat_out;
          acc   <= '0;
          b_idx <= '0;
          if (c_idx == C_LAST) begin
            out_vld_r <= 1'b1;
            state     <= DONE;
          end else begin
            c_idx <= c_idx + 1'b1;
            state <= MAC;
          end
        end
        DONE: begin
          in_rdy_r <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_rdy   = in_rdy_r;
  assign bus.out_vld  = out_vld_r;
  assign bus.out_data = out_data_r;
  assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Testbench for eq_band_mixer: directed frames, expected results queued at issue and checked by a monitor.
// Latency: checks out_vld at accept cycle + CH*(NB+1)+1.
// Backpressure: exercises drop-while-busy, overrun set/clear and reset mid-frame.
module tb_eq_band_mixer;
  localparam int W   = 16;
  localparam int NB  = 5;
  localparam int CH  = 2;
  localparam int GW  = 12;
  localparam int LAT = CH*(NB+1)+1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eq_band_mixer_if #(.W(W), .NB(NB), .CH(CH), .GW(GW)) bus ();

  eq_band_mixer #(.W(W), .NB(NB), .CH(CH), .GW(GW), .VOL_STEP(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [CH*W-1:0] data;
    int              t;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_t = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp_v);
    end
  endtask

  // Monitor: every out_vld pulse must match the oldest queued frame, data and timing.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_vld === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got out_vld=1 (data 0x%0h) want no output", bus.out_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("latency", cyc, e.t + LAT);
      end
    end
  end

  function automatic logic [CH*NB*W-1:0] rep_b(input logic [W-1:0] v);
    return {(CH*NB){v}};
  endfunction

  function automatic logic [NB*GW-1:0] rep_g(input logic [GW-1:0] v);
    return {NB{v}};
  endfunction

  task automatic send(input logic [CH*NB*W-1:0] bi, input logic [NB*GW-1:0] gi,
                      input logic [GW-1:0] vi, input logic [CH*W-1:0] ed, input bit push);
    int n = 0;
    @(negedge clk);
    while (bus.in_rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_rdy !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL in_rdy_timeout: got in_rdy=%b want 1", bus.in_rdy);
    end else begin
      bus.band_in  = bi;
      bus.gain     = gi;
      bus.volume   = vi;
      bus.band_vld = 1'b1;
      last_t       = cyc;
      if (push) sbq.push_back('{ed, cyc});
      @(posedge clk);
      #1;
      bus.band_vld = 1'b0;
      // Scramble inputs: the frame in flight must use the captured copy.
      bus.band_in  = ~bi;
      bus.gain     = ~gi;
      bus.volume   = ~vi;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH*NB*W-1:0] bi;
    logic [NB*GW-1:0]   gi;
    int                 t_a;
    logic [W-1:0]       ev;

    rst_n        = 1'b1;
    bus.band_vld = 1'b0;
    bus.band_in  = '0;
    bus.gain     = '0;
    bus.volume   = '0;
    bus.clr_ovr  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_overrun", bus.overrun, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

`ifdef EQ_VOL_RAMP_EN
    // ch0 t=512, so output = 512*vol/2048 = vol/4; volume ramps 16 per frame from 0.
    bi = '0;
    bi[2*W +: W] = 16'h0400;
    gi = rep_g(12'h800);
    gi[2*GW +: GW] = 12'h400;
    for (int k = 1; k <= 130; k++) begin
      ev = (k < 128) ? W'(4*k) : 16'h0200;
      send(bi, gi, 12'h800, {16'h0000, ev}, 1'b1);
    end
    send(bi, gi, 12'h7F0, 32'h0000_01FC, 1'b1);
    send(bi, gi, 12'h7F8, 32'h0000_01FE, 1'b1);
    send(bi, gi, 12'h000, 32'h0000_01FA, 1'b1);
    drain();
`else
    // Unity gain/volume: 5 bands of 0x1000 sum to 0x5000.
    send(rep_b(16'h1000), rep_g(12'h800), 12'h800, 32'h5000_5000, 1'b1);
    t_a = last_t;
    @(negedge clk);
    chk("busy_in_rdy", bus.in_rdy, 0);
    // Positive and negative saturation, issued back to back.
    send(rep_b(16'h7FFF), rep_g(12'hFFF), 12'hFFF, 32'h7FFF_7FFF, 1'b1);
    chk("b2b_spacing", last_t - t_a, CH*(NB+1)+2);
    send(rep_b(16'h8000), rep_g(12'hFFF), 12'hFFF, 32'h8000_8000, 1'b1);
    drain();

    // Single band on ch0: 0x400*0x400 >>> 11 = 0x200.
    bi = '0;
    bi[2*W +: W] = 16'h0400;
    gi = rep_g(12'h800);
    gi[2*GW +: GW] = 12'h400;
    send(bi, gi, 12'h800, 32'h0000_0200, 1'b1);
    // Gain 0 on band 0 kills its large sample; ch1 negative.
    send({{NB{16'hF000}}, {4{16'h1000}}, 16'h7FFF}, {{4{12'h800}}, 12'h000}, 12'h800,
         32'hC000_4000, 1'b1);
    // Volume 0 silences.
    send(rep_b(16'h1000), rep_g(12'h800), 12'h000, 32'h0000_0000, 1'b1);
    // -1 * tiny gain floors to -1, not 0.
    bi = '0;
    bi[0 +: W] = 16'hFFFF;
    send(bi, rep_g(12'h001), 12'h800, 32'h0000_FFFF, 1'b1);
    drain();

    // Frame offered while busy is dropped; first frame unaffected.
    send(rep_b(16'h1000), rep_g(12'h800), 12'h800, 32'h5000_5000, 1'b1);
    repeat (5) @(negedge clk);
    bus.band_in  = rep_b(16'h7FFF);
    bus.band_vld = 1'b1;
    @(negedge clk);
    bus.band_vld = 1'b0;
    chk("overrun_set", bus.overrun, 1);
    drain();
    chk("overrun_sticky", bus.overrun, 1);
    bus.clr_ovr = 1'b1;
    @(negedge clk);
    bus.clr_ovr = 1'b0;
    chk("overrun_clr", bus.overrun, 0);

    // Clear and a new overrun in the same cycle: clear wins.
    send(rep_b(16'h1000), rep_g(12'h800), 12'h800, 32'h5000_5000, 1'b1);
    @(negedge clk);
    bus.band_vld = 1'b1;
    bus.clr_ovr  = 1'b1;
    @(negedge clk);
    bus.band_vld = 1'b0;
    bus.clr_ovr  = 1'b0;
    chk("clr_wins", bus.overrun, 0);
    drain();

    // Reset mid-frame: frame discarded, outputs back to reset values at once.
    send(rep_b(16'h1000), rep_g(12'h800), 12'h800, 32'h0, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_vld", bus.out_vld, 0);
    chk("midrst_in_rdy", bus.in_rdy, 1);
    chk("midrst_out_data", bus.out_data, 0);
    repeat (2) @(negedge clk);
    chk("midrst_in_rdy_held", bus.in_rdy, 1);
    rst_n = 1'b1;
    bi = '0;
    bi[2*W +: W] = 16'h0400;
    send(bi, gi, 12'h800, 32'h0000_0200, 1'b1);
    drain();
    repeat (20) @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
